uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver: the receive-side counterpart of the baud tick generator and UART transmitter.
//  Oversamples i_rx at OVS x baud. Resyncs to each start edge and samples every bit at mid-bit.
//  Delivers one byte per frame as a single-cycle valid pulse to the host logic.
//  Sits between the board RX pin and the command/loopback logic, in the clk domain.
// PARAMETERS
//  CLK_FREQ  100_000_000  system clock frequency, Hz
//  BAUD      115200       line rate, bit/s
//  OVS       16           oversampling factor; even, >=8
//  DIV       CLK_FREQ/(BAUD*OVS) (=54)  clocks per oversample tick, derived, not overridden
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  i_rx         in   1  serial line, idle high, asynchronous to clk
//  o_data       out  8  last good byte, LSB received first
//  o_valid      out  1  1-clk pulse: o_data updated with a good frame
//  o_frame_err  out  1  1-clk pulse: stop bit sampled low
//  o_busy       out  1  high from start detect until return to IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): o_data=0, o_valid=0, o_frame_err=0, o_busy=0, state IDLE.
//    Synchronizer flops reset to 1 (line idle); all counters reset to 0.
//  - i_rx passes through a 2-FF synchronizer (rx_s). No other logic uses raw i_rx.
//  - Oversample divider: counts 0..DIV-1 and emits a tick on DIV-1.
//    It is cleared on start detection, so phase is aligned to the edge.
//    It holds at 0 while in IDLE.
//  - FSM IDLE->START->DATA->STOP->IDLE, plus WAIT_HI:
//    IDLE:  falling edge on rx_s (previous 1, now 0) -> START. Clear divider and tick count. o_busy=1.
//    START: on tick OVS/2, sample rx_s. If 0 -> DATA, bit index 0.
//           If 1 -> glitch: return to IDLE, no output pulse.
//    DATA:  every OVS ticks, shift rx_s in at bit [idx] (LSB first). After idx 7 -> STOP.
//    STOP:  OVS ticks after bit 7, sample rx_s.
//           1 -> o_data<=shift reg, o_valid=1 for 1 clk, then IDLE.
//           0 -> o_frame_err=1 for 1 clk, o_data unchanged, then WAIT_HI.
//    WAIT_HI: stay until rx_s==1, then IDLE. Breaks and held-low lines never retrigger.
//  - Timing: raw i_rx falls at cycle 0 -> rx_s low at cycle 2 (start detect).
//    Start-bit sample at cycle 434; bit n sample at 434+864*(n+1); stop sample at 8210.
//    o_valid/o_frame_err high in cycle 8211.
//  - Back-to-back frames: the next start edge is accepted in the first IDLE cycle after the pulse.
//  - Line low at reset release: no start until rx_s has been seen high, because edge detection is required.
//  - Reset asserted mid-frame: abort immediately. The partial byte is discarded and no pulse is emitted.
//  - o_valid and o_frame_err are never high in the same cycle.
//  - No host backpressure; the host must consume o_data before the next o_valid.
//  - Counter widths: $clog2(DIV), $clog2(OVS), 3-bit bit index. All wrap only under explicit clear.
// STRUCTURE
//  - uart_pkg: FSM state localparams (IDLE, START, DATA, STOP, WAIT_HI).
//    Also holds the DATA_BITS=8 constant and the DIV computation function, shared with TX.
//  - Sub-module uart_os_tick: divider with clear and enable, tick output.
//    Same shape as the TX baud generator, instantiated once here.
//  - Synchronizer, FSM, shift register and output registers stay in this file.
// TESTING (defaults; bench drives i_rx at exactly 868 clk/bit)
//  1. Frame 0x55 -> o_valid for 1 clk at cycle 8211 after the start edge, o_data=8'h55, o_frame_err=0.
//  2. Frames 0x00, 0xFF, 0xA5 back to back (no idle gap) -> three o_valid pulses with the correct bytes in order.
//  3. Low pulse of 300 clks on idle line -> no o_valid, no o_frame_err, o_busy returns to 0 by cycle ~436.
//  4. Frame 0x3C with stop bit forced low, line then held low for 3 bit times -> one o_frame_err pulse,
//     o_data keeps its previous value, no retrigger until line high. Then frame 0x12 -> o_valid, 0x12.
//  5. rst pulsed low mid-frame (at bit 4) -> all outputs 0 immediately. The next full frame 0x81 is received correctly.
//  6. Bench baud skewed +/-3% (842/894 clk/bit) on frame 0xC3 -> o_valid with o_data=8'hC3 in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants, FSM state type and baud-divider helper shared by
// the UART receiver and transmitter.
package uart_pkg;

  // Payload bits per frame (8N1).
  localparam int unsigned DATA_BITS = 8;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } uart_rx_state_t;

  // Clocks per oversample tick for a given clock, line rate and oversampling factor.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversample tick generator.
// Counts 0..DIV-1 while enabled and pulses tick on DIV-1. Clearing or
// disabling forces the count back to 0, so after a clear the first tick
// comes exactly DIV cycles later.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-low reset
//   clr   in  synchronous clear of the phase counter
//   en    in  count enable; counter holds at 0 when low
//   tick  out 1-clk pulse every DIV enabled cycles
module uart_os_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Oversamples the synchronised line at OVS x baud, realigns to every start
// edge and samples each bit at mid-bit. A good frame updates o_data with a
// single-cycle o_valid pulse; a low stop bit gives a single-cycle
// o_frame_err pulse and the receiver then waits for the line to go high.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   i_rx         in   serial line, idle high, asynchronous to clk
//   o_data       out  last good byte, LSB received first
//   o_valid      out  1-clk pulse, o_data updated with a good frame
//   o_frame_err  out  1-clk pulse, stop bit sampled low
//   o_busy       out  high from start detect until back in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned OVS      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int unsigned TW  = $clog2(OVS);
  localparam int unsigned IW  = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  // ---------------------------------------------------------------------
  // Line synchroniser and falling-edge detect
  // ---------------------------------------------------------------------
  logic       rx_meta;
  logic       rx_s;
  logic       rx_prev;
  logic [1:0] sync_fill;
  logic       start_edge;

  // The synchroniser resets to idle-high, but that reset value is not a real
  // observation of the line. sync_fill marks when rx_s carries a genuine
  // sample; until then rx_prev is held low so a line that is already low at
  // reset release cannot look like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b0;
      sync_fill <= '0;
    end else begin
      rx_meta   <= i_rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= rx_s & sync_fill[1];
    end
  end

  assign start_edge = rx_prev && !rx_s;

  // ---------------------------------------------------------------------
  // Oversample tick, phase-aligned to the start edge
  // ---------------------------------------------------------------------
  uart_rx_state_t state, state_nx;
  logic           div_clr;
  logic           os_tick;

  uart_os_tick #(
    .DIV(DIV)
  ) u_os_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (state != IDLE),
    .tick (os_tick)
  );

  // ---------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------
  logic [TW-1:0]        tick_cnt, tick_nx;
  logic [IW-1:0]        bit_idx, idx_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic [DATA_BITS-1:0] data_nx;
  logic                 valid_nx;
  logic                 ferr_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nx;
      tick_cnt    <= tick_nx;
      bit_idx     <= idx_nx;
      shift       <= shift_nx;
      o_data      <= data_nx;
      o_valid     <= valid_nx;
      o_frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    idx_nx   = bit_idx;
    shift_nx = shift;
    data_nx  = o_data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    div_clr  = 1'b0;

    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nx = START;
          div_clr  = 1'b1;
          tick_nx  = '0;
        end
      end

      // Half a bit into the start bit: confirm the line is still low.
      START: begin
        if (os_tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_nx = '0;
            if (!rx_s) begin
              state_nx = DATA;
              idx_nx   = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (os_tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_nx           = '0;
            shift_nx[bit_idx] = rx_s;
            if (bit_idx == IDX_LAST) begin
              state_nx = STOP;
            end else begin
              idx_nx = bit_idx + 1'b1;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (os_tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_nx = '0;
            if (rx_s) begin
              data_nx  = shift;
              valid_nx = 1'b1;
              state_nx = IDLE;
            end else begin
              ferr_nx  = 1'b1;
              state_nx = WAIT_HI;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end

      // A break or stuck-low line must return high before a new start edge.
      WAIT_HI: begin
        if (rx_s) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule
